// File: rtl/vanilla_scoreboard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_scoreboard_tracker_pkg
// Brief    : Shared types for the scoreboard tracker and its stall profiler:
//            per-register scoreboard info, stall categories, trace records.
// Revision : 1.0 - initial release
// ============================================================================
package vanilla_scoreboard_tracker_pkg;

    localparam int reg_addr_width_gp  = 5;
    localparam int reg_els_gp         = 32;
    localparam int num_stall_cat_gp   = 8;
    localparam int stall_len_width_gp = 16;

    // Integer register file scoreboard info (one per register).
    typedef struct packed {
        logic remote_dram_seq_load;
        logic remote_dram_load;
        logic remote_dram_amo;
        logic remote_global_load;
        logic remote_group_load;
        logic idiv;
    } vanilla_isb_info_s;

    // Float register file scoreboard info (one per register).
    typedef struct packed {
        logic remote_dram_seq_load;
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic fdiv_fsqrt;
    } vanilla_fsb_info_s;

    // Encoding order is also the attribution priority (lowest value wins).
    typedef enum logic [2:0] {
        CAT_SEQ_DRAM = 3'd0,
        CAT_DRAM     = 3'd1,
        CAT_AMO      = 3'd2,
        CAT_GLOBAL   = 3'd3,
        CAT_GROUP    = 3'd4,
        CAT_IDIV     = 3'd5,
        CAT_FDIV     = 3'd6,
        CAT_OTHER    = 3'd7
    } stall_cat_e;

    typedef struct packed {
        stall_cat_e                    cat;
        logic [stall_len_width_gp-1:0] len;
    } stall_trace_s;

endpackage
`default_nettype wire

// File: rtl/vanilla_sb_stall_classify.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_sb_stall_classify
// Brief    : Combinational stall-cause classifier. ORs the scoreboard info of
//            every valid ID operand and priority-encodes the result.
// Revision : 1.0 - initial release
// ============================================================================
module vanilla_sb_stall_classify
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter int reg_addr_width_lp = reg_addr_width_gp
)(
    input  logic                                    rs1_v_i,
    input  logic                                    rs2_v_i,
    input  logic                                    rs3_v_i,
    input  logic                                    rd_v_i,
    input  logic                                    rs1_fp_i,
    input  logic                                    rs2_fp_i,
    input  logic                                    rd_fp_i,
    input  logic [reg_addr_width_lp-1:0]            rs1_id_i,
    input  logic [reg_addr_width_lp-1:0]            rs2_id_i,
    input  logic [reg_addr_width_lp-1:0]            rs3_id_i,
    input  logic [reg_addr_width_lp-1:0]            rd_id_i,
    input  vanilla_isb_info_s [reg_els_gp-1:0]      int_sb_i,
    input  vanilla_fsb_info_s [reg_els_gp-1:0]      float_sb_i,
    output stall_cat_e                              cat_o
);

    logic [3:0]                        w_v;
    logic [3:0]                        w_fp;
    logic [3:0][reg_addr_width_lp-1:0] w_id;

    // rs3 only exists for fused float ops, so it always reads the float file.
    assign w_v  = {rd_v_i, rs3_v_i, rs2_v_i, rs1_v_i};
    assign w_fp = {rd_fp_i, 1'b1, rs2_fp_i, rs1_fp_i};
    assign w_id = {rd_id_i, rs3_id_i, rs2_id_i, rs1_id_i};

    logic w_seq, w_dram, w_amo, w_global, w_group, w_idiv, w_fdiv;

    // Gather the union of pending-cause bits across all checked operands.
    always_comb begin
        w_seq    = 1'b0;
        w_dram   = 1'b0;
        w_amo    = 1'b0;
        w_global = 1'b0;
        w_group  = 1'b0;
        w_idiv   = 1'b0;
        w_fdiv   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_v[i]) begin
                if (w_fp[i]) begin
                    w_seq    = w_seq    | float_sb_i[w_id[i]].remote_dram_seq_load;
                    w_dram   = w_dram   | float_sb_i[w_id[i]].remote_dram_load;
                    w_global = w_global | float_sb_i[w_id[i]].remote_global_load;
                    w_group  = w_group  | float_sb_i[w_id[i]].remote_group_load;
                    w_fdiv   = w_fdiv   | float_sb_i[w_id[i]].fdiv_fsqrt;
                end else begin
                    w_seq    = w_seq    | int_sb_i[w_id[i]].remote_dram_seq_load;
                    w_dram   = w_dram   | int_sb_i[w_id[i]].remote_dram_load;
                    w_amo    = w_amo    | int_sb_i[w_id[i]].remote_dram_amo;
                    w_global = w_global | int_sb_i[w_id[i]].remote_global_load;
                    w_group  = w_group  | int_sb_i[w_id[i]].remote_group_load;
                    w_idiv   = w_idiv   | int_sb_i[w_id[i]].idiv;
                end
            end
        end
    end

    // Longest-latency cause wins the attribution.
    always_comb begin
        cat_o = CAT_OTHER;
        if      (w_seq)    cat_o = CAT_SEQ_DRAM;
        else if (w_dram)   cat_o = CAT_DRAM;
        else if (w_amo)    cat_o = CAT_AMO;
        else if (w_global) cat_o = CAT_GLOBAL;
        else if (w_group)  cat_o = CAT_GROUP;
        else if (w_idiv)   cat_o = CAT_IDIV;
        else if (w_fdiv)   cat_o = CAT_FDIV;
    end

endmodule
`default_nettype wire

// File: rtl/vanilla_sb_stall_profiler.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_sb_stall_profiler
// Brief    : Per-category dependency-stall cycle counters, stall episode
//            tracking and a single-entry trace record buffer.
// Revision : 1.0 - initial release
// ============================================================================
module vanilla_sb_stall_profiler
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter int cnt_width_p       = 32,
    parameter int len_width_p       = 16,
    parameter int reg_addr_width_lp = reg_addr_width_gp
)(
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        stall_depend_i,
    input  logic                                        stall_all_i,
    input  logic                                        flush_i,
    input  logic                                        rs1_v_i,
    input  logic                                        rs2_v_i,
    input  logic                                        rs3_v_i,
    input  logic                                        rd_v_i,
    input  logic                                        rs1_fp_i,
    input  logic                                        rs2_fp_i,
    input  logic                                        rd_fp_i,
    input  logic [reg_addr_width_lp-1:0]                rs1_id_i,
    input  logic [reg_addr_width_lp-1:0]                rs2_id_i,
    input  logic [reg_addr_width_lp-1:0]                rs3_id_i,
    input  logic [reg_addr_width_lp-1:0]                rd_id_i,
    input  vanilla_isb_info_s [reg_els_gp-1:0]          int_sb_i,
    input  vanilla_fsb_info_s [reg_els_gp-1:0]          float_sb_i,
    input  logic                                        clear_i,
    output logic [num_stall_cat_gp-1:0][cnt_width_p-1:0] cat_cycles_o,
    output logic [cnt_width_p-1:0]                      max_run_o,
    output logic [cnt_width_p-1:0]                      drop_cnt_o,
    output logic                                        trace_v_o,
    output stall_trace_s                                trace_o,
    input  logic                                        trace_yumi_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ep_state_e;

    stall_cat_e w_cat;
    logic       w_qual;
    logic       w_end;

    vanilla_sb_stall_classify #(
        .reg_addr_width_lp (reg_addr_width_lp)
    ) u_classify (
        .rs1_v_i    (rs1_v_i),
        .rs2_v_i    (rs2_v_i),
        .rs3_v_i    (rs3_v_i),
        .rd_v_i     (rd_v_i),
        .rs1_fp_i   (rs1_fp_i),
        .rs2_fp_i   (rs2_fp_i),
        .rd_fp_i    (rd_fp_i),
        .rs1_id_i   (rs1_id_i),
        .rs2_id_i   (rs2_id_i),
        .rs3_id_i   (rs3_id_i),
        .rd_id_i    (rd_id_i),
        .int_sb_i   (int_sb_i),
        .float_sb_i (float_sb_i),
        .cat_o      (w_cat)
    );

    assign w_qual = stall_depend_i & ~stall_all_i & ~flush_i;

    logic [num_stall_cat_gp-1:0][cnt_width_p-1:0] cat_cycles_d, cat_cycles_q;
    ep_state_e                                    state_d, state_q;
    stall_cat_e                                   ep_cat_d, ep_cat_q;
    logic [len_width_p-1:0]                       ep_len_d, ep_len_q;
    logic [cnt_width_p-1:0]                       run_cnt_d, run_cnt_q;
    logic [cnt_width_p-1:0]                       max_run_d, max_run_q;
    logic                                         rec_pend_d, rec_pend_q;
    stall_trace_s                                 rec_d, rec_q;
    logic                                         trace_v_d, trace_v_q;
    stall_trace_s                                 trace_d, trace_q;
    logic [cnt_width_p-1:0]                       drop_cnt_d, drop_cnt_q;

    // Saturating per-category cycle counters; clear overrides any increment.
    always_comb begin
        cat_cycles_d = cat_cycles_q;
        if (clear_i) begin
            cat_cycles_d = '0;
        end else if (w_qual && !(&cat_cycles_q[w_cat])) begin
            cat_cycles_d[w_cat] = cat_cycles_q[w_cat] + cnt_width_p'(1);
        end
    end

    // Episode FSM: the record length saturates, but max_run uses the wider
    // run count so long episodes still rank correctly.
    always_comb begin
        state_d    = state_q;
        ep_cat_d   = ep_cat_q;
        ep_len_d   = ep_len_q;
        run_cnt_d  = run_cnt_q;
        w_end      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_qual) begin
                    state_d   = ST_RUN;
                    ep_cat_d  = w_cat;
                    ep_len_d  = len_width_p'(1);
                    run_cnt_d = cnt_width_p'(1);
                end
            end
            ST_RUN: begin
                if (stall_all_i) begin
                    state_d = ST_RUN;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (stall_depend_i) begin
                    if (!(&ep_len_q))  ep_len_d  = ep_len_q + len_width_p'(1);
                    if (!(&run_cnt_q)) run_cnt_d = run_cnt_q + cnt_width_p'(1);
                end else begin
                    state_d = ST_IDLE;
                    w_end   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage the finished record for one cycle, then write or drop it.
    always_comb begin
        rec_pend_d = w_end;
        rec_d      = rec_q;
        max_run_d  = max_run_q;
        trace_v_d  = trace_v_q & ~trace_yumi_i;
        trace_d    = trace_q;
        drop_cnt_d = drop_cnt_q;
        if (w_end) begin
            rec_d.cat = ep_cat_q;
            rec_d.len = stall_len_width_gp'(ep_len_q);
            if (run_cnt_q > max_run_q) max_run_d = run_cnt_q;
        end
        if (rec_pend_q) begin
            if (!trace_v_q || trace_yumi_i) begin
                trace_v_d = 1'b1;
                trace_d   = rec_q;
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + cnt_width_p'(1);
            end
        end
        if (clear_i) begin
            max_run_d  = '0;
            drop_cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cat_cycles_q <= '0;
            state_q      <= ST_IDLE;
            ep_cat_q     <= CAT_SEQ_DRAM;
            ep_len_q     <= '0;
            run_cnt_q    <= '0;
            max_run_q    <= '0;
            rec_pend_q   <= 1'b0;
            rec_q        <= '0;
            trace_v_q    <= 1'b0;
            trace_q      <= '0;
            drop_cnt_q   <= '0;
        end else begin
            cat_cycles_q <= cat_cycles_d;
            state_q      <= state_d;
            ep_cat_q     <= ep_cat_d;
            ep_len_q     <= ep_len_d;
            run_cnt_q    <= run_cnt_d;
            max_run_q    <= max_run_d;
            rec_pend_q   <= rec_pend_d;
            rec_q        <= rec_d;
            trace_v_q    <= trace_v_d;
            trace_q      <= trace_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign cat_cycles_o = cat_cycles_q;
    assign max_run_o    = max_run_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign trace_v_o    = trace_v_q;
    assign trace_o      = trace_q;

endmodule
`default_nettype wire

// File: tb/tb_vanilla_sb_stall_profiler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vanilla_sb_stall_profiler
// Brief    : Scoreboard bench for the stall profiler with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vanilla_sb_stall_profiler;
    import vanilla_scoreboard_tracker_pkg::*;

    localparam int CW   = 8;
    localparam int LW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i = 1'b1;
    logic stall_depend_i = 0, stall_all_i = 0, flush_i = 0, clear_i = 0;
    logic rs1_v_i = 0, rs2_v_i = 0, rs3_v_i = 0, rd_v_i = 0;
    logic rs1_fp_i = 0, rs2_fp_i = 0, rd_fp_i = 0;
    logic [reg_addr_width_gp-1:0] rs1_id_i = 0, rs2_id_i = 0, rs3_id_i = 0, rd_id_i = 0;
    vanilla_isb_info_s [reg_els_gp-1:0] int_sb_i = '0;
    vanilla_fsb_info_s [reg_els_gp-1:0] float_sb_i = '0;
    logic [num_stall_cat_gp-1:0][CW-1:0] cat_cycles_o;
    logic [CW-1:0] max_run_o, drop_cnt_o;
    logic          trace_v_o;
    stall_trace_s  trace_o;
    logic          trace_yumi_i = 0;

    vanilla_sb_stall_profiler #(
        .cnt_width_p (CW),
        .len_width_p (LW)
    ) dut (
        .clk_i (clk), .reset_i (reset_i),
        .stall_depend_i (stall_depend_i), .stall_all_i (stall_all_i), .flush_i (flush_i),
        .rs1_v_i (rs1_v_i), .rs2_v_i (rs2_v_i), .rs3_v_i (rs3_v_i), .rd_v_i (rd_v_i),
        .rs1_fp_i (rs1_fp_i), .rs2_fp_i (rs2_fp_i), .rd_fp_i (rd_fp_i),
        .rs1_id_i (rs1_id_i), .rs2_id_i (rs2_id_i), .rs3_id_i (rs3_id_i), .rd_id_i (rd_id_i),
        .int_sb_i (int_sb_i), .float_sb_i (float_sb_i), .clear_i (clear_i),
        .cat_cycles_o (cat_cycles_o), .max_run_o (max_run_o), .drop_cnt_o (drop_cnt_o),
        .trace_v_o (trace_v_o), .trace_o (trace_o), .trace_yumi_i (trace_yumi_i)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    stall_trace_s exp_q[$];
    int           exp_cat[8];
    int           exp_max, exp_drop;
    bit           ep_active;
    int           ep_cat, ep_cnt;
    bit           pend;
    stall_trace_s pend_rec;
    bit           rand_ops  = 0;
    int           yumi_pct  = 100;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cause of the current stall: the highest-priority pending reason found on
    // any checked operand, OTHER when none.
    function automatic int model_cat();
        bit [7:0] found = '0;
        bit                        v [4];
        bit                        fp[4];
        logic [reg_addr_width_gp-1:0] id[4];
        v  = '{rs1_v_i, rs2_v_i, rs3_v_i, rd_v_i};
        fp = '{rs1_fp_i, rs2_fp_i, 1'b1, rd_fp_i};
        id = '{rs1_id_i, rs2_id_i, rs3_id_i, rd_id_i};
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) continue;
            if (fp[i]) begin
                if (float_sb_i[id[i]].remote_dram_seq_load) found[0] = 1;
                if (float_sb_i[id[i]].remote_dram_load)     found[1] = 1;
                if (float_sb_i[id[i]].remote_global_load)   found[3] = 1;
                if (float_sb_i[id[i]].remote_group_load)    found[4] = 1;
                if (float_sb_i[id[i]].fdiv_fsqrt)           found[6] = 1;
            end else begin
                if (int_sb_i[id[i]].remote_dram_seq_load)   found[0] = 1;
                if (int_sb_i[id[i]].remote_dram_load)       found[1] = 1;
                if (int_sb_i[id[i]].remote_dram_amo)        found[2] = 1;
                if (int_sb_i[id[i]].remote_global_load)     found[3] = 1;
                if (int_sb_i[id[i]].remote_group_load)      found[4] = 1;
                if (int_sb_i[id[i]].idiv)                   found[5] = 1;
            end
        end
        for (int c = 0; c < 7; c++) if (found[c]) return c;
        return 7;
    endfunction

    task automatic model_reset();
        foreach (exp_cat[c]) exp_cat[c] = 0;
        exp_max = 0; exp_drop = 0;
        ep_active = 0; ep_cnt = 0; ep_cat = 0;
        pend = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs that were just sampled.
    task automatic model_step();
        bit qual;
        int c, m;
        if (pend) begin
            if (exp_q.size() == 0) exp_q.push_back(pend_rec);
            else if (exp_drop < CMAX) exp_drop++;
        end
        pend = 0;
        qual = stall_depend_i && !stall_all_i && !flush_i;
        c = model_cat();
        if (qual && exp_cat[c] < CMAX) exp_cat[c]++;
        if (!ep_active) begin
            if (qual) begin ep_active = 1; ep_cat = c; ep_cnt = 1; end
        end else if (stall_all_i) begin
            ep_active = 1;
        end else if (flush_i) begin
            ep_active = 0;
        end else if (stall_depend_i) begin
            ep_cnt++;
        end else begin
            ep_active    = 0;
            pend         = 1;
            pend_rec.cat = stall_cat_e'(ep_cat);
            pend_rec.len = 16'((ep_cnt > LMAX) ? LMAX : ep_cnt);
            m = (ep_cnt > CMAX) ? CMAX : ep_cnt;
            if (m > exp_max) exp_max = m;
        end
        if (clear_i) begin
            foreach (exp_cat[k]) exp_cat[k] = 0;
            exp_max = 0; exp_drop = 0;
        end
    endtask

    task automatic randomize_ops();
        {rs1_v_i, rs2_v_i, rs3_v_i, rd_v_i} = 4'($urandom);
        {rs1_fp_i, rs2_fp_i, rd_fp_i}       = 3'($urandom);
        rs1_id_i = 5'($urandom); rs2_id_i = 5'($urandom);
        rs3_id_i = 5'($urandom); rd_id_i  = 5'($urandom);
        for (int i = 0; i < reg_els_gp; i++) begin
            int_sb_i[i]   = 6'($urandom) & 6'($urandom) & 6'($urandom);
            float_sb_i[i] = 5'($urandom) & 5'($urandom) & 5'($urandom);
        end
    endtask

    task automatic ops_none();
        {rs1_v_i, rs2_v_i, rs3_v_i, rd_v_i} = '0;
        {rs1_fp_i, rs2_fp_i, rd_fp_i}       = '0;
        int_sb_i   = '0;
        float_sb_i = '0;
    endtask

    // Present one cycle of inputs, wait for the edge, then update the model.
    task automatic step(input bit dep, input bit all, input bit fl, input bit clr);
        stall_depend_i = dep; stall_all_i = all; flush_i = fl; clear_i = clr;
        if (rand_ops) randomize_ops();
        trace_yumi_i = (exp_q.size() > 0) && ($urandom_range(0, 99) < yumi_pct);
        @(posedge clk); #2;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #1 reset_i = 1'b1;
        #1;
        chk("rst_trace_v", trace_v_o, 0);
        chk("rst_trace",   trace_o, 0);
        chk("rst_max_run", max_run_o, 0);
        chk("rst_drop",    drop_cnt_o, 0);
        @(posedge clk); #2;
        model_reset();
        reset_i = 1'b0;
    endtask

    // Monitor: compare outputs against the model and pop accepted records.
    always @(negedge clk) begin
        if (!reset_i) begin
            for (int c = 0; c < 8; c++) chk($sformatf("cat_cycles[%0d]", c), cat_cycles_o[c], exp_cat[c]);
            chk("max_run", max_run_o, exp_max);
            chk("drop_cnt", drop_cnt_o, exp_drop);
            chk("trace_v", trace_v_o, exp_q.size() > 0);
            if (trace_yumi_i && exp_q.size() > 0) begin
                chk("trace_rec", trace_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_trace", trace_o, 0);
        reset_i = 1'b0;

        // DRAM load on x5 through rs1, 4-cycle episode.
        ops_none();
        int_sb_i[5].remote_dram_load = 1'b1;
        rs1_v_i = 1; rs1_id_i = 5;
        repeat (4) step(1, 0, 0, 0);
        idle(4);

        // Group load on int x7 outranks fdiv on float x3.
        ops_none();
        float_sb_i[3].fdiv_fsqrt      = 1'b1;
        int_sb_i[7].remote_group_load = 1'b1;
        rs1_v_i = 1; rs1_id_i = 7;
        rs2_v_i = 1; rs2_fp_i = 1; rs2_id_i = 3;
        repeat (2) step(1, 0, 0, 0);
        idle(4);

        // Global freeze inside an episode holds the length.
        repeat (3) step(1, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        idle(4);

        // Flush aborts the episode without a record.
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        idle(4);

        // Full buffer with no consumer drops the second record.
        yumi_pct = 0;
        repeat (2) step(1, 0, 0, 0);
        idle(2);
        repeat (6) step(1, 0, 0, 0);
        idle(3);
        yumi_pct = 100;
        idle(3);

        // Long episode saturates counter, length field and max run; then clear.
        ops_none();
        int_sb_i[5].remote_dram_load = 1'b1;
        rs1_v_i = 1; rs1_id_i = 5;
        repeat (300) step(1, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 1);
        idle(3);

        // Randomized traffic, including clear coinciding with activity.
        rand_ops = 1;
        yumi_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 2);
        end

        // Reset in the middle of an episode.
        repeat (3) step(1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 2);
        end

        rand_ops = 0;
        yumi_pct = 100;
        idle(6);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
